nand_pipe: RTL and testbench
============================

NAND_PIPE -- requirements
Module: nand_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal 1..64).
REQ-002 Parameter: INV_MODE_EN_DEFAULT, default 0, reset value of the mode register (0 = NAND network, 1 = complemented/AND network).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream operand set valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b, c, d  input  WIDTH each  operand vectors.
REQ-008 inv  input  1  per-transaction mode, captured with operands (0 NAND, 1 complemented).
REQ-009 out_valid  output  1  result set valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 y, e, f, g  output  WIDTH each  result vectors.
REQ-012 txn_count  output  16  completed-transaction counter (see Configuration).

Function
REQ-013 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-014 Bitwise results per transaction: e = ~(a&b); y = ~(a&b&c&d); f = ~(e&c); g = ~(e&f); with inv=1 every result SHALL be the bitwise complement of the inv=0 value.
REQ-015 Two registered stages: S1 holds e, y, c, inv, s1_valid; S2 holds y, e, f, g (post-inv), s2_valid = out_valid.
REQ-016 S1 SHALL compute e and y from inputs; S2 SHALL compute f, g from S1 registers; no combinational path from a..d to y..g.
REQ-017 Latency: result SHALL be on outputs exactly 2 cycles after input handshake when out_ready held 1.
REQ-018 S2 advance = ~s2_valid | out_ready; S1 advance = ~s1_valid | S2 advance; in_ready SHALL equal S1 advance.
REQ-019 Throughput SHALL be one transaction per cycle with out_ready=1 continuously.
REQ-020 out_ready=0 with both stages full: in_ready SHALL be 0; y..g and out_valid SHALL hold stable until handshake.
REQ-021 Simultaneous input and output handshake in the same cycle SHALL move both without loss or duplication.
REQ-022 Transaction order SHALL be preserved; no result dropped, none emitted twice.
REQ-023 in_valid low: bubbles SHALL propagate; out_valid deasserts after last result accepted.
REQ-024 Data registers SHALL load only when their stage advances with valid data entering.

Reset
REQ-025 rst_n low SHALL immediately clear s1_valid, out_valid; y, e, f, g SHALL read 0; txn_count SHALL read 0.
REQ-026 Reset mid-transaction SHALL discard all in-flight results; none emitted after release.
REQ-027 in_ready SHALL be 1 in first cycle after rst_n deasserts.

Configuration
REQ-028 Macro NAND_PIPE_STATS_EN defined: txn_count SHALL increment by 1 per output handshake, saturating at 16'hFFFF.
REQ-029 Macro undefined: txn_count SHALL be constant 0 and no counter logic synthesised; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 a=b=c=d=FF, inv=0, out_ready=1 -> 2 cycles later out_valid=1, y=00, e=00, f=FF, g=FF.
REQ-031 a=0F, b=FF, c=33, d=FF, inv=0 -> y=FC, e=F0, f=CF, g=3F; same with inv=1 -> y=03, e=0F, f=30, g=C0.
REQ-032 Stream 10 random sets back-to-back, out_ready=1 -> 10 results in order, one per cycle, in_ready constantly 1.
REQ-033 3 transactions sent, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, outputs stable; out_ready=1 -> all 3 delivered in order.
REQ-034 rst_n pulsed low with 2 in flight -> out_valid=0 immediately, no stale result after release, in_ready=1.
REQ-035 NAND_PIPE_STATS_EN defined, 70000 handshakes -> txn_count=FFFF; undefined -> txn_count=0.

Source files
------------

// File: rtl/nand_pipe.sv
// ============================================================================
// Module   : nand_pipe
// Brief    : Two-stage valid/ready NAND network (e, y, f, g) with per-txn invert.
//            Optional macro NAND_PIPE_STATS_EN adds a saturating txn_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nand_pipe #(
  parameter int WIDTH               = 8,
  parameter bit INV_MODE_EN_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [15:0]      txn_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_e_q, s1_e_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic             s1_inv_q, s1_inv_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] g_q, g_d;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] s2_f_raw;
  logic [WIDTH-1:0] s2_g_raw;
  logic [WIDTH-1:0] s2_mask;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 keeps the un-inverted network values; inversion is applied once in stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_e_d     = s1_e_q;
    s1_y_d     = s1_y_q;
    s1_c_d     = s1_c_q;
    s1_inv_d   = s1_inv_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_e_d   = ~(a & b);
        s1_y_d   = ~(a & b & c & d);
        s1_c_d   = c;
        s1_inv_d = inv;
      end
    end
  end

  assign s2_f_raw = ~(s1_e_q & s1_c_q);
  assign s2_g_raw = ~(s1_e_q & s2_f_raw);
  assign s2_mask  = {WIDTH{s1_inv_q}};

  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    e_d        = e_q;
    f_d        = f_q;
    g_d        = g_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d = s1_y_q ^ s2_mask;
        e_d = s1_e_q ^ s2_mask;
        f_d = s2_f_raw ^ s2_mask;
        g_d = s2_g_raw ^ s2_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_e_q     <= '0;
      s1_y_q     <= '0;
      s1_c_q     <= '0;
      s1_inv_q   <= INV_MODE_EN_DEFAULT;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      e_q        <= '0;
      f_q        <= '0;
      g_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_e_q     <= s1_e_d;
      s1_y_q     <= s1_y_d;
      s1_c_q     <= s1_c_d;
      s1_inv_q   <= s1_inv_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      e_q        <= e_d;
      f_q        <= f_d;
      g_q        <= g_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign e         = e_q;
  assign f         = f_q;
  assign g         = g_q;

`ifdef NAND_PIPE_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (s2_valid_q && out_ready && (txn_count_q != 16'hFFFF)) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_q <= 16'd0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;
`else
  assign txn_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nand_pipe.sv
// ============================================================================
// Module   : tb_nand_pipe
// Brief    : Self-checking bench for nand_pipe (WIDTH=8) with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nand_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c, d;
  logic       inv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y, e, f, g;
  logic [15:0] txn_count;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [7:0] y;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] g;
    int         born;
  } exp_t;

  exp_t        q[$];
  exp_t        m_new;
  logic        exp_ov;
  logic [15:0] exp_cnt;
  logic        rnd;

  nand_pipe #(.WIDTH(8), .INV_MODE_EN_DEFAULT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .inv       (inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .e         (e),
    .f         (f),
    .g         (g),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result rules straight from the function definition, complement applied last.
  function automatic exp_t model(input logic [7:0] va, vb, vc, vd, input logic vi);
    exp_t       r;
    logic [7:0] ee, ff;
    ee     = ~(va & vb);
    ff     = ~(ee & vc);
    r.e    = vi ? ~ee : ee;
    r.y    = vi ? (va & vb & vc & vd) : ~(va & vb & vc & vd);
    r.f    = vi ? ~ff : ff;
    r.g    = vi ? (ee & ff) : ~(ee & ff);
    r.born = 0;
    return r;
  endfunction

  // An item is visible at the output once it has crossed two edges; occupancy 2 with a stalled sink blocks input.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 16'd0;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_outputs", {32'd0, y, e, f, g}, 64'd0);
      chk("rst_txn_count", {48'd0, txn_count}, 64'd0);
    end else begin
      exp_ov = (q.size() > 0) && ((cyc - q[0].born) >= 2);
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || out_ready});
      if (out_valid && q.size() > 0)
        chk("result", {32'd0, y, e, f, g}, {32'd0, q[0].y, q[0].e, q[0].f, q[0].g});
`ifdef NAND_PIPE_STATS_EN
      chk("txn_count", {48'd0, txn_count}, {48'd0, exp_cnt});
`else
      chk("txn_count_zero", {48'd0, txn_count}, 64'd0);
`endif
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        m_new      = model(a, b, c, d, inv);
        m_new.born = cyc;
        q.push_back(m_new);
      end
    end
  end

  task automatic drive(input logic [7:0] va, vb, vc, vd, input logic vi);
    a        = va;
    b        = vb;
    c        = vc;
    d        = vd;
    inv      = vi;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #2;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Single transaction into an empty pipe; checks exact two-cycle latency and literal results.
  task automatic one_shot(input string nm, input logic [7:0] va, vb, vc, vd, input logic vi,
                          input logic [31:0] exp_yefg);
    drive(va, vb, vc, vd, vi);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk({nm, "_lat1_out_valid"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_yefg"}, {32'd0, y, e, f, g}, {32'd0, exp_yefg});
    idle(2);
  endtask

  initial begin
    int   w;
    exp_t r;
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    exp_cnt   = 16'd0;
    rnd       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    {a, b, c, d} = '0;
    inv       = 1'b0;

    r = model(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("model_all_ff", {32'd0, r.y, r.e, r.f, r.g}, {32'd0, 32'h0000FFFF});
    r = model(8'h0F, 8'hFF, 8'h33, 8'hFF, 1'b0);
    chk("model_mix_inv0", {32'd0, r.y, r.e, r.f, r.g}, {32'd0, 32'hFCF0CF3F});
    r = model(8'h0F, 8'hFF, 8'h33, 8'hFF, 1'b1);
    chk("model_mix_inv1", {32'd0, r.y, r.e, r.f, r.g}, {32'd0, 32'h030F30C0});

    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_yefg", {32'd0, y, e, f, g}, 64'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #2;

    one_shot("all_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 32'h0000FFFF);
    one_shot("mix_inv0", 8'h0F, 8'hFF, 8'h33, 8'hFF, 1'b0, 32'hFCF0CF3F);
    one_shot("mix_inv1", 8'h0F, 8'hFF, 8'h33, 8'hFF, 1'b1, 32'h030F30C0);

    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      wait_accept(w);
      chk("stream_no_wait", 64'(w), 64'd0);
    end
    idle(4);
    chk("stream_drained", 64'(q.size()), 64'd0);

    out_ready = 1'b0;
    drive(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    wait_accept(w);
    drive(8'hA5, 8'h5A, 8'hC3, 8'h3C, 1'b1);
    wait_accept(w);
    drive(8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_accept(w);
    idle(4);
    chk("stall_drained", 64'(q.size()), 64'd0);

    rnd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      wait_accept(w);
      idle($urandom_range(0, 2));
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("random_drained", 64'(q.size()), 64'd0);

    drive(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    wait_accept(w);
    drive(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
    wait_accept(w);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_yefg", {32'd0, y, e, f, g}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    idle(4);
    chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);

`ifdef NAND_PIPE_STATS_EN
    for (int i = 0; i < 70000; i++) begin
      drive(8'(i), 8'(i >> 8), 8'hA5, 8'h5A, 1'(i));
      wait_accept(w);
    end
    idle(4);
    chk("stats_saturated", {48'd0, txn_count}, 64'h000000000000FFFF);
`else
    chk("stats_disabled", {48'd0, txn_count}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
